// File: rtl/priority_encoder_pipe.sv
// priority_encoder_pipe: registered priority encoder with valid/ready handshake.
// Define ROUND_ROBIN_EN for a rotating-pointer search instead of fixed lowest-index priority.
module priority_encoder_pipe #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi,
  output logic             out_valid,
  input  logic             out_ready
);
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_zero;
  logic             r_multi;
  logic [WIDTH-1:0] w_rot;
  logic [IDX_W-1:0] w_j;
  logic [IDX_W-1:0] w_idx;
  logic             w_zero;
  logic             w_multi;
  logic             w_take;
  assign in_ready  = !r_valid || out_ready;
  assign w_take    = in_valid && in_ready;
  assign w_zero    = ~|in_vec;
  assign w_multi   = |(in_vec & (in_vec - WIDTH'(1)));
  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_zero  = r_zero;
  assign out_multi = r_multi;
  always_comb begin
    w_j = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (w_rot[i]) w_j = IDX_W'(i);
  end
`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]   r_ptr;
  logic [2*WIDTH-1:0] w_dbl;
  logic [IDX_W:0]     w_sum;
  // Rotate so the pointer position lands at bit 0, then map the hit back modulo WIDTH.
  assign w_dbl = {in_vec, in_vec} >> r_ptr;
  assign w_rot = w_dbl[WIDTH-1:0];
  assign w_sum = {1'b0, r_ptr} + {1'b0, w_j};
  assign w_idx = w_zero ? '0 :
                 (w_sum >= (IDX_W+1)'(WIDTH)) ? IDX_W'(w_sum - (IDX_W+1)'(WIDTH)) : w_sum[IDX_W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (w_take && !w_zero) r_ptr <= (w_idx == IDX_W'(WIDTH - 1)) ? '0 : w_idx + IDX_W'(1);
  end
`else
  assign w_rot = in_vec;
  assign w_idx = w_j;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_zero  <= 1'b0;
      r_multi <= 1'b0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_idx   <= w_idx;
      r_zero  <= w_zero;
      r_multi <= w_multi;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_priority_encoder_pipe.sv
// tb_priority_encoder_pipe: randomized and directed checks against a scan-based reference model.
module tb_priority_encoder_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_vec = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] out_idx;
  logic       out_zero;
  logic       out_multi;
  logic       out_valid;
  logic       out_ready = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       m_valid = 1'b0;
  logic [2:0] m_idx = '0;
  logic       m_zero = 1'b0;
  logic       m_multi = 1'b0;
  int         m_ptr = 0;

  priority_encoder_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
    .out_idx(out_idx), .out_zero(out_zero), .out_multi(out_multi),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First set bit met when walking p, p+1, ... around the ring.
  function automatic logic [2:0] ref_idx(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++)
      if (((v >> ((p + k) % 8)) & 8'd1) != 8'd0) return 3'((p + k) % 8);
    return 3'd0;
  endfunction

  task automatic cycle(input logic [7:0] vec, input logic v, input logic ordy);
    logic exp_rdy;
    logic take;
    in_vec = vec;
    in_valid = v;
    out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    chk("in_ready", in_ready, exp_rdy);
    take = v && exp_rdy;
    @(posedge clk);
    if (take) begin
      m_valid = 1'b1;
      m_zero = (vec == 8'd0);
      m_multi = ($countones(vec) >= 2);
      m_idx = ref_idx(vec, m_ptr);
`ifdef ROUND_ROBIN_EN
      if (vec != 8'd0) m_ptr = (int'(m_idx) + 1) % 8;
`endif
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_idx", out_idx, m_idx);
      chk("out_zero", out_zero, m_zero);
      chk("out_multi", out_multi, m_multi);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_multi", out_multi, 0);
`ifdef ROUND_ROBIN_EN
    chk("rst_ptr", dut.r_ptr, 0);
`endif
    in_valid = 1'b1;
    in_vec = 8'hFF;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_xfer", out_valid, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    m_valid = 1'b0;
    m_ptr = 0;
  endtask

  initial begin
    logic [7:0] rv;
    #1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rv = 8'd1 << i;
      cycle(rv, 1'b1, 1'b1);
`ifndef ROUND_ROBIN_EN
      chk("onehot_idx", out_idx, i);
`endif
    end
    cycle(8'h00, 1'b1, 1'b1);
    chk("zero_flag", out_zero, 1);
    chk("zero_idx", out_idx, 0);
`ifndef ROUND_ROBIN_EN
    cycle(8'b1010_0100, 1'b1, 1'b1);
    chk("fixed_idx", out_idx, 2);
    chk("fixed_multi", out_multi, 1);
`endif
    cycle(8'h24, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(8'h10, 1'b1, 1'b0);
    chk("stall_valid", out_valid, 1);
    chk("stall_multi", out_multi, 1);
    cycle(8'h00, 1'b0, 1'b1);
    chk("drain_valid", out_valid, 0);
    do_reset();
`ifdef ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      cycle(8'hFF, 1'b1, 1'b1);
      chk("rr_ff_idx", out_idx, i);
    end
    cycle(8'h81, 1'b1, 1'b1);
    chk("rr_81_idx", out_idx, 7);
    cycle(8'h81, 1'b1, 1'b1);
    chk("rr_wrap_idx", out_idx, 0);
`endif
    cycle(8'h08, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b0);
    do_reset();
    cycle(8'h40, 1'b1, 1'b1);
    chk("post_rst_accept", out_valid, 1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rv = 8'd0;
        1: rv = 8'd1 << $urandom_range(0, 7);
        default: rv = 8'($urandom);
      endcase
      cycle(rv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
